uart_rx_packet: RTL and testbench
=================================

Name: uart_rx_packet

Overview:
- Serial receive front end that feeds the controller unit.
- Samples the UART line, deserialises 8N1 bytes and assembles two-byte request packets: command byte first, address byte second.
- Presents next_command / next_address with a level new_data flag, held until the controller clears it.
- Drops malformed bytes and stale half-packets so the controller never sees a mixed packet.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit (50 MHz / 9600 baud); must be ≥ 4.
- TIMEOUT_CLKS, 104160, max idle cycles between end of byte 0 and start bit of byte 1 (about 20 bit times).

Ports:
- clock  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- rx  input  1  UART serial line, idle high, asynchronous to clock
- clear  input  1  controller request to discard the held packet and restart assembly (driven by rest_uart_rx)
- next_command  output  8  command byte of the last complete packet
- next_address  output  8  address byte of the last complete packet
- new_data  output  1  level; high while an unconsumed packet is held
- frame_error  output  1  one-cycle pulse when a stop bit samples low
- overrun  output  1  one-cycle pulse when a packet completes while new_data is already high

Behaviour:
- Reset (async, high): all outputs 0; bit FSM in IDLE; assembler expects byte 0; synchroniser flops forced to 1.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- Bit FSM states:
  - IDLE: wait for rx_s == 0 → START, counter cleared.
  - START: count to CLKS_PER_BIT/2 − 1 (integer division). If rx_s is still 0 → DATA. If rx_s is 1 (false start) → IDLE, no error.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits; bit index 0..7; after bit 7 → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s == 1: byte_done pulses for one cycle with the byte.
    - rx_s == 0: frame_error pulses, byte discarded, assembler returns to byte 0 (half-packet dropped).
    - Both cases → IDLE. On a framing error, return to IDLE only once rx_s == 1, so a break condition does not retrigger.
- Assembler:
  - WAIT_B0 + byte_done: latch cmd_tmp; → WAIT_B1; timeout counter cleared.
  - WAIT_B1: timeout counter runs only while the bit FSM is in IDLE. When it reaches TIMEOUT_CLKS, cmd_tmp is discarded → WAIT_B0, with no output change.
  - WAIT_B1 + byte_done: next_command ← cmd_tmp, next_address ← byte, new_data ← 1, in the cycle after byte_done. If new_data was already 1, overrun pulses in that same cycle and the outputs are overwritten. → WAIT_B0.
- Latency: new_data rises 2 cycles after the stop-bit sample of byte 1, and about 2 synchroniser cycles plus 19.5 bit times after the byte 0 start edge for back-to-back bytes.
- clear (synchronous, level):
  - new_data, next_command, next_address ← 0; assembler → WAIT_B0; timeout counter cleared.
  - The bit FSM is not affected; a byte in flight completes and counts as byte 0.
  - If clear and packet completion coincide, clear wins: the packet is discarded and no overrun is flagged.
  - clear held high keeps the assembler in WAIT_B0, and every byte_done is dropped.
- Values are not range-checked; the controller validates command and address.
- frame_error and overrun never assert in the same cycle as reset or while reset is high.

Test Plan:
- CLKS_PER_BIT=16, TIMEOUT_CLKS=400. Send bytes 0x04 then 0x1F back to back → new_data=1, next_command=0x04, next_address=0x1F, held until clear; clear → all three 0 next cycle.
- Send 0x01, idle 500 clocks, send 0x05 and 0x02 → byte 0x01 dropped by timeout; output command 0x05, address 0x02; no error pulses.
- Send 0x03 with stop bit forced low, then 0x07, 0x00 → one frame_error pulse; packet = cmd 0x07, addr 0x00; new_data=1.
- 5-cycle low glitch on rx while idle → no byte received, outputs unchanged, no frame_error.
- Packet (0x04, 0x01) without clear, then packet (0x06, 0x01) → overrun pulses once; outputs 0x06/0x01; new_data stays 1.
- Assert clear on the cycle a packet completes → new_data stays 0, no overrun. Also assert reset mid-byte → outputs 0 immediately, and the next full packet is received correctly.

Source files
------------

// File: rtl/uart_rx_packet.sv
// UART 8N1 receiver that pairs bytes into command/address packets for the controller.
// Packets are held with a level new_data flag until the controller clears them.
module uart_rx_packet #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_CLKS = 104160
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       clear,
  output logic [7:0] next_command,
  output logic [7:0] next_address,
  output logic       new_data,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} bit_state_t;
  typedef enum logic {WAIT_B0, WAIT_B1} asm_state_t;

  bit_state_t       bit_state, bit_next;
  asm_state_t       asm_state, asm_next;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg, cmd_tmp;
  logic [TO_W-1:0]  to_cnt;
  logic             bit_tc, load_half, load_bit, shift_en, stop_ok, stop_bad;
  logic             byte_done, latch_cmd, complete;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign bit_tc = (bit_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) bit_state <= IDLE;
    else       bit_state <= bit_next;
  end

  // BREAK holds off after a framing error until the line returns high
  always_comb begin
    bit_next  = bit_state;
    load_half = 1'b0;
    load_bit  = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (bit_state)
      IDLE:  if (!rx_s) begin bit_next = START; load_half = 1'b1; end
      START: if (bit_tc) begin
               if (!rx_s) begin bit_next = DATA; load_bit = 1'b1; end
               else       bit_next = IDLE;
             end
      DATA:  if (bit_tc) begin
               shift_en = 1'b1;
               load_bit = 1'b1;
               if (bit_idx == 3'd7) bit_next = STOP;
             end
      STOP:  if (bit_tc) begin
               if (rx_s) begin stop_ok = 1'b1; bit_next = IDLE; end
               else      begin stop_bad = 1'b1; bit_next = BREAK; end
             end
      BREAK: if (rx_s) bit_next = IDLE;
      default: bit_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      byte_done   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (load_half)     bit_cnt <= HALF_LOAD;
      else if (load_bit) bit_cnt <= BIT_LOAD;
      else if (!bit_tc)  bit_cnt <= bit_cnt - 1'b1;
      if (bit_state == START) bit_idx <= '0;
      else if (shift_en)      bit_idx <= bit_idx + 1'b1;
      if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
      byte_done   <= stop_ok;
      frame_error <= stop_bad;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) asm_state <= WAIT_B0;
    else       asm_state <= asm_next;
  end

  // clear and framing errors both abandon any half-assembled packet
  always_comb begin
    asm_next  = asm_state;
    latch_cmd = 1'b0;
    complete  = 1'b0;
    if (clear || frame_error) begin
      asm_next = WAIT_B0;
    end else begin
      case (asm_state)
        WAIT_B0: if (byte_done) begin asm_next = WAIT_B1; latch_cmd = 1'b1; end
        WAIT_B1: if (byte_done) begin
                   asm_next = WAIT_B0;
                   complete = 1'b1;
                 end else if (to_cnt == '0) begin
                   asm_next = WAIT_B0;
                 end
        default: asm_next = WAIT_B0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt       <= TO_LOAD;
      cmd_tmp      <= '0;
      next_command <= '0;
      next_address <= '0;
      new_data     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (clear || latch_cmd) to_cnt <= TO_LOAD;
      else if (asm_state == WAIT_B1 && bit_state == IDLE && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
      if (latch_cmd) cmd_tmp <= shift_reg;
      overrun <= complete && new_data;
      if (clear) begin
        next_command <= '0;
        next_address <= '0;
        new_data     <= 1'b0;
      end else if (complete) begin
        next_command <= cmd_tmp;
        next_address <= shift_reg;
        new_data     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed bench for uart_rx_packet: packets scored through a queue, pulses counted.
module tb_uart_rx_packet;
  localparam int CPB = 16;
  localparam int TO  = 400;

  logic       clock = 1'b0;
  logic       reset, rx, clear;
  logic [7:0] next_command, next_address;
  logic       new_data, frame_error, overrun;

  int vectors = 0;
  int miscompares = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [15:0] exp_q[$];
  logic        nd_prev = 1'b0;
  logic [7:0]  cmd_prev = '0, addr_prev = '0;

  uart_rx_packet #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clock(clock), .reset(reset), .rx(rx), .clear(clear),
    .next_command(next_command), .next_address(next_address),
    .new_data(new_data), .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame starting at a negedge; clr_at pulses clear inside the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int clr_at);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_val;
    for (int k = 0; k < CPB; k++) begin
      if (k == clr_at) clear = 1'b1;
      if (k == clr_at + 1) clear = 1'b0;
      @(negedge clock);
    end
    rx = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_nd", new_data, 0);
    chk("clear_cmd", next_command, 0);
    chk("clear_addr", next_address, 0);
  endtask

  // Monitor: every new or changed held packet must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (new_data && (!nd_prev || next_command != cmd_prev || next_address != addr_prev)) begin
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("sb_cmd", next_command, e[15:8]);
          chk("sb_addr", next_address, e[7:0]);
        end
      end
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
    nd_prev   = new_data;
    cmd_prev  = next_command;
    addr_prev = next_address;
  end

  initial begin
    reset = 1'b1; rx = 1'b1; clear = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_fe", frame_error, 0);
    chk("rst_ov", overrun, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_nd", new_data, 0);
    chk("rst_cmd", next_command, 0);
    chk("rst_addr", next_address, 0);
    repeat (4) @(negedge clock);

    // back-to-back packet, held until clear
    exp_q.push_back(16'h041F);
    send_byte(8'h04, 1'b1, -1);
    send_byte(8'h1F, 1'b1, -1);
    repeat (2) @(negedge clock);
    chk("p1_nd", new_data, 1);
    chk("p1_cmd", next_command, 8'h04);
    chk("p1_addr", next_address, 8'h1F);
    repeat (50) @(negedge clock);
    chk("p1_hold", new_data, 1);
    do_clear();

    // lone byte times out, following pair assembles cleanly
    send_byte(8'h01, 1'b1, -1);
    repeat (500) @(negedge clock);
    chk("to_nd", new_data, 0);
    exp_q.push_back(16'h0502);
    send_byte(8'h05, 1'b1, -1);
    send_byte(8'h02, 1'b1, -1);
    repeat (2) @(negedge clock);
    chk("to_cmd", next_command, 8'h05);
    chk("to_addr", next_address, 8'h02);
    chk("to_fe", fe_cnt, 0);
    chk("to_ov", ov_cnt, 0);
    do_clear();

    // framing error drops the byte
    send_byte(8'h03, 1'b0, -1);
    repeat (2 * CPB) @(negedge clock);
    chk("fe_once", fe_cnt, 1);
    exp_q.push_back(16'h0700);
    send_byte(8'h07, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    repeat (2) @(negedge clock);
    chk("fe_nd", new_data, 1);
    chk("fe_cmd", next_command, 8'h07);
    chk("fe_addr", next_address, 8'h00);

    // short glitch is a false start
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clock);
    chk("gl_nd", new_data, 1);
    chk("gl_cmd", next_command, 8'h07);
    chk("gl_addr", next_address, 8'h00);
    chk("gl_fe", fe_cnt, 1);
    do_clear();

    // overrun when a second packet lands unconsumed
    exp_q.push_back(16'h0401);
    send_byte(8'h04, 1'b1, -1);
    send_byte(8'h01, 1'b1, -1);
    repeat (4) @(negedge clock);
    chk("ov_none_yet", ov_cnt, 0);
    exp_q.push_back(16'h0601);
    send_byte(8'h06, 1'b1, -1);
    send_byte(8'h01, 1'b1, -1);
    repeat (2) @(negedge clock);
    chk("ov_once", ov_cnt, 1);
    chk("ov_nd", new_data, 1);
    chk("ov_cmd", next_command, 8'h06);
    chk("ov_addr", next_address, 8'h01);

    // clear coinciding with completion wins
    send_byte(8'h08, 1'b1, -1);
    send_byte(8'h09, 1'b1, 11);
    repeat (4) @(negedge clock);
    chk("cc_nd", new_data, 0);
    chk("cc_cmd", next_command, 0);
    chk("cc_ov", ov_cnt, 1);

    // reset mid-byte, then a full packet
    exp_q.push_back(16'h0A0B);
    send_byte(8'h0A, 1'b1, -1);
    send_byte(8'h0B, 1'b1, -1);
    repeat (2) @(negedge clock);
    chk("pre_rst_nd", new_data, 1);
    rx = 1'b0;
    repeat (40) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_nd", new_data, 0);
    chk("mid_rst_cmd", next_command, 0);
    chk("mid_rst_addr", next_address, 0);
    @(negedge clock);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    exp_q.push_back(16'h0C0D);
    send_byte(8'h0C, 1'b1, -1);
    send_byte(8'h0D, 1'b1, -1);
    repeat (2) @(negedge clock);
    chk("post_rst_nd", new_data, 1);
    chk("post_rst_cmd", next_command, 8'h0C);
    chk("post_rst_addr", next_address, 8'h0D);
    chk("final_fe", fe_cnt, 1);
    chk("final_ov", ov_cnt, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
